// File: rtl/adc_sample_scheduler_if.sv
// Serializer-side handshake bundle for adc_sample_scheduler.
//   master (scheduler):  drives spi_start_o / spi_rden_o, observes serializer
//                        state, last-bit pulse, FIFO push and FIFO full.
//   slave  (serializer): the mirror image.
// Signal names keep the scheduler's original port names.
interface adc_sample_scheduler_if;
  logic       spi_start_o;      // one-cycle conversion start
  logic       spi_rden_o;       // read-enable / pair toggle enable
  logic [1:0] spi_fsm_st_i;     // 0 idle, 1 transmit, 2 done
  logic       spi_tfer_done_i;  // last-bit pulse
  logic       sensor_push_i;    // FIFO push of a completed pair
  logic       rx_fifo_full_i;   // RX FIFO full

  modport master (
    output spi_start_o, spi_rden_o,
    input  spi_fsm_st_i, spi_tfer_done_i, sensor_push_i, rx_fifo_full_i
  );

  modport slave (
    input  spi_start_o, spi_rden_o,
    output spi_fsm_st_i, spi_tfer_done_i, sensor_push_i, rx_fifo_full_i
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Conversion scheduler for the AD7476 serializer.
// Issues spi_start pulses every max(rate_div_i, MIN_PERIOD) clocks, holds the
// serializer read-enable for the length of a run, stops after pair_count_i
// sample pairs (0 = continuous) or when enable_i drops, and skips conversions
// while the RX FIFO is full, counting them as overflows.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   enable_i            run request (level)
//   rate_div_i          sample period in clocks (clamped to MIN_PERIOD)
//   pair_count_i        pairs per run, 0 = continuous
//   clr_ovf_i           clears overflow_o / ovf_cnt_o
//   spi                 serializer handshake (master side)
//   busy_o, done_o      run in progress / one-cycle end-of-run pulse
//   overflow_o          sticky skipped-conversion flag
//   ovf_cnt_o           saturating skipped-conversion count
//   pairs_o             pairs pushed in current/last run
module adc_sample_scheduler #(
  parameter int unsigned MIN_PERIOD = 18,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned OVF_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CNT_W-1:0]     rate_div_i,
  input  logic [CNT_W-1:0]     pair_count_i,
  input  logic                 clr_ovf_i,
  adc_sample_scheduler_if.master spi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [OVF_W-1:0]     ovf_cnt_o,
  output logic [CNT_W-1:0]     pairs_o
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CONV  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W:0]   conv_cnt;

  logic [CNT_W-1:0] eff_period;
  logic [CNT_W:0]   conv_next;
  logic [CNT_W:0]   conv_target;
  logic             last_conv;
  logic             ser_ready;
  logic             slot;

  always_comb begin
    eff_period  = (rate_div_i < MIN_P) ? MIN_P : rate_div_i;
    conv_next   = conv_cnt + (CNT_W+1)'(1);
    conv_target = {pair_count_i, 1'b0};
    last_conv   = (pair_count_i != '0) && (conv_next == conv_target);
    // The done state always returns to idle on the next edge, so a start
    // registered while the serializer is in done lands on an idle serializer.
    // This keeps back-to-back starts exactly one period apart.
    ser_ready   = (spi.spi_fsm_st_i == 2'd0) || (spi.spi_fsm_st_i == 2'd2);
    slot        = (period_cnt == ONE) && ser_ready;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      period_cnt      <= '0;
      conv_cnt        <= '0;
      spi.spi_start_o <= 1'b0;
      spi.spi_rden_o  <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      overflow_o      <= 1'b0;
      ovf_cnt_o       <= '0;
      pairs_o         <= '0;
    end else begin
      spi.spi_start_o <= 1'b0;
      done_o          <= 1'b0;

      if (clr_ovf_i) begin
        overflow_o <= 1'b0;
        ovf_cnt_o  <= '0;
      end

      if ((state != IDLE) && spi.sensor_push_i)
        pairs_o <= pairs_o + ONE;

      case (state)
        IDLE: begin
          if (enable_i) begin
            state          <= WAIT;
            period_cnt     <= ONE;
            conv_cnt       <= '0;
            pairs_o        <= '0;
            spi.spi_rden_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end

        WAIT: begin
          if (!enable_i) begin
            state <= DRAIN;
          end else if (slot) begin
            period_cnt <= eff_period;
            if (!spi.rx_fifo_full_i) begin
              spi.spi_start_o <= 1'b1;
              state           <= CONV;
            end else if (!clr_ovf_i) begin
              overflow_o <= 1'b1;
              if (ovf_cnt_o != '1)
                ovf_cnt_o <= ovf_cnt_o + OVF_W'(1);
            end
          end else if (period_cnt > ONE) begin
            period_cnt <= period_cnt - ONE;
          end
        end

        CONV: begin
          if (period_cnt > ONE)
            period_cnt <= period_cnt - ONE;
          if (spi.spi_tfer_done_i) begin
            conv_cnt <= conv_next;
            if (last_conv || !enable_i)
              state <= DRAIN;
            else
              state <= WAIT;
          end
        end

        DRAIN: begin
          state          <= IDLE;
          done_o         <= 1'b1;
          spi.spi_rden_o <= 1'b0;
          busy_o         <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
module tb_adc_sample_scheduler;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OVF_W = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             enable;
  logic             clr_ovf;
  logic [CNT_W-1:0] rate_div;
  logic [CNT_W-1:0] pair_count;
  logic             busy, done, overflow;
  logic [OVF_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] pairs;

  adc_sample_scheduler_if spi_if ();

  adc_sample_scheduler #(
    .MIN_PERIOD(18),
    .CNT_W     (CNT_W),
    .OVF_W     (OVF_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .enable_i    (enable),
    .rate_div_i  (rate_div),
    .pair_count_i(pair_count),
    .clr_ovf_i   (clr_ovf),
    .spi         (spi_if),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow),
    .ovf_cnt_o   (ovf_cnt),
    .pairs_o     (pairs)
  );

  always #5 clk = ~clk;

  // Serializer model: start in cycle N -> transmit N+1..N+16 (last bit N+16),
  // done N+17, idle N+18. Pushes on the done cycle of the second half of a pair.
  logic [1:0] ser_st;
  logic [3:0] bitc;
  logic       half, pair_done;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ser_st    <= 2'd0;
      bitc      <= 4'd0;
      half      <= 1'b0;
      pair_done <= 1'b0;
    end else begin
      case (ser_st)
        2'd0: if (spi_if.spi_start_o) begin ser_st <= 2'd1; bitc <= 4'd0; end
        2'd1: begin
          bitc <= bitc + 4'd1;
          if (bitc == 4'd15) begin
            ser_st    <= 2'd2;
            pair_done <= spi_if.spi_rden_o & half;
            half      <= spi_if.spi_rden_o ? ~half : 1'b0;
          end
        end
        default: ser_st <= 2'd0;
      endcase
      if (!spi_if.spi_rden_o) half <= 1'b0;
    end
  end

  assign spi_if.spi_fsm_st_i    = ser_st;
  assign spi_if.spi_tfer_done_i = (ser_st == 2'd1) && (bitc == 4'd15);
  assign spi_if.sensor_push_i   = (ser_st == 2'd2) && pair_done;

  // Event monitor, sampled on the falling edge.
  int cyc = 0, n_start = 0, n_push = 0, n_done = 0;
  int start_t [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (spi_if.spi_start_o) begin
      if (n_start < 64) start_t[n_start] <= cyc + 1;
      n_start <= n_start + 1;
    end
    if (spi_if.sensor_push_i) n_push <= n_push + 1;
    if (done) n_done <= n_done + 1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int  base;
    bit  ok;
    base = n_done;
    ok   = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      sync();
      if (n_done != base) begin
        ok     = 1'b1;
        enable = 1'b0;
      end
    end
    enable = 1'b0;
    check_eq(tag, ok, 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && n_start < target; i++) sync();
    check_eq(tag, n_start >= target, 1);
  endtask

  // Finite run with an empty FIFO: 2*npairs starts spaced gap apart.
  task automatic run_basic(input int rate, input int npairs, input int gap);
    int s0, d0, p0, c0;
    sync();
    rate_div   = CNT_W'(rate);
    pair_count = CNT_W'(npairs);
    s0 = n_start; d0 = n_done; p0 = n_push;
    enable = 1'b1;
    c0 = cyc;
    wait_done($sformatf("r%0d_done_seen", rate), 400);
    check_eq($sformatf("r%0d_starts", rate), n_start - s0, 2 * npairs);
    check_eq($sformatf("r%0d_first_start", rate), start_t[s0], c0 + 2);
    for (int i = 1; i < 2 * npairs; i++)
      check_eq($sformatf("r%0d_gap%0d", rate, i), start_t[s0+i] - start_t[s0+i-1], gap);
    repeat (30) sync();
    check_eq($sformatf("r%0d_pairs", rate), pairs, npairs);
    check_eq($sformatf("r%0d_pushes", rate), n_push - p0, npairs);
    check_eq($sformatf("r%0d_done_cnt", rate), n_done - d0, 1);
    check_eq($sformatf("r%0d_no_restart", rate), n_start - s0, 2 * npairs);
    check_eq($sformatf("r%0d_busy", rate), busy, 0);
    check_eq($sformatf("r%0d_rden", rate), spi_if.spi_rden_o, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, d0, p0, c0;
    rst_i = 1'b1; enable = 1'b0; clr_ovf = 1'b0;
    rate_div = '0; pair_count = '0;
    spi_if.rx_fifo_full_i = 1'b0;
    repeat (3) sync();
    check_eq("rst_start", spi_if.spi_start_o, 0);
    check_eq("rst_rden", spi_if.spi_rden_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_ovf_cnt", ovf_cnt, 0);
    check_eq("rst_pairs", pairs, 0);
    rst_i = 1'b0;
    repeat (2) sync();

    run_basic(18, 2, 18);
    run_basic(5, 1, 18);
    run_basic(25, 1, 25);

    // FIFO full for three slots at period 40, continuous run.
    sync();
    rate_div = 16'd40; pair_count = '0;
    spi_if.rx_fifo_full_i = 1'b1;
    s0 = n_start;
    enable = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 200 && ovf_cnt != 8'd3; i++) sync();
    check_eq("full_ovf_cnt", ovf_cnt, 3);
    check_eq("full_overflow", overflow, 1);
    check_eq("full_no_start", n_start - s0, 0);
    spi_if.rx_fifo_full_i = 1'b0;
    wait_starts("full_start_seen", s0 + 1, 100);
    check_eq("full_start_time", start_t[s0], c0 + 122);
    check_eq("full_busy", busy, 1);
    enable = 1'b0;
    wait_done("full_done_seen", 100);
    check_eq("full_pairs_half", pairs, 0);
    check_eq("full_ovf_kept", ovf_cnt, 3);
    clr_ovf = 1'b1;
    sync();
    clr_ovf = 1'b0;
    check_eq("clr_ovf_cnt", ovf_cnt, 0);
    check_eq("clr_overflow", overflow, 0);

    // Continuous run, enable dropped during the third conversion.
    repeat (2) sync();
    rate_div = 16'd18; pair_count = '0;
    s0 = n_start; d0 = n_done; p0 = n_push;
    enable = 1'b1;
    wait_starts("abort_third_start", s0 + 3, 100);
    repeat (5) sync();
    enable = 1'b0;
    wait_done("abort_done_seen", 100);
    repeat (40) sync();
    check_eq("abort_starts", n_start - s0, 3);
    check_eq("abort_pairs", pairs, 1);
    check_eq("abort_pushes", n_push - p0, 1);
    check_eq("abort_done_cnt", n_done - d0, 1);

    // 300 full slots saturate the counter; a clear on a slot edge wins.
    sync();
    rate_div = 16'd18; pair_count = '0;
    spi_if.rx_fifo_full_i = 1'b1;
    s0 = n_start;
    enable = 1'b1;
    c0 = cyc;
    while (cyc < c0 + 1 + 18 * 300) sync();
    check_eq("sat_ovf_cnt", ovf_cnt, 255);
    check_eq("sat_overflow", overflow, 1);
    check_eq("sat_no_start", n_start - s0, 0);
    clr_ovf = 1'b1;
    sync();
    clr_ovf = 1'b0;
    check_eq("clr_vs_slot_cnt", ovf_cnt, 0);
    check_eq("clr_vs_slot_flag", overflow, 0);
    while (cyc < c0 + 2 + 18 * 301) sync();
    check_eq("after_clr_cnt", ovf_cnt, 1);
    spi_if.rx_fifo_full_i = 1'b0;
    enable = 1'b0;
    wait_done("sat_done_seen", 50);

    // Reset in the middle of a conversion, then a clean restart.
    sync();
    rate_div = 16'd18; pair_count = '0;
    spi_if.rx_fifo_full_i = 1'b1;
    s0 = n_start;
    enable = 1'b1;
    for (int i = 0; i < 20 && ovf_cnt == 8'd1; i++) sync();
    for (int i = 0; i < 20 && ovf_cnt != 8'd2; i++) sync();
    check_eq("mid_ovf_before", ovf_cnt, 2);
    spi_if.rx_fifo_full_i = 1'b0;
    wait_starts("mid_start_seen", s0 + 1, 50);
    repeat (4) sync();
    check_eq("mid_busy_before", busy, 1);
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rden", spi_if.spi_rden_o, 0);
    check_eq("mid_rst_start", spi_if.spi_start_o, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_ovf_cnt", ovf_cnt, 0);
    check_eq("mid_rst_overflow", overflow, 0);
    enable = 1'b0;
    sync();
    rst_i = 1'b0;
    sync();
    s0 = n_start;
    enable = 1'b1;
    c0 = cyc;
    wait_starts("restart_start_seen", s0 + 1, 10);
    check_eq("restart_first_start", start_t[s0], c0 + 2);
    enable = 1'b0;
    wait_done("restart_done_seen", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
